debounce_edge: RTL and testbench
================================

# debounce_edge

Debounce and event-extraction stage that sits directly downstream of the 2-stage input synchronizer. It takes the already-synchronized button/switch level and accepts a level change only after it has been stable for a programmable number of clocks. It emits a clean debounced level, single-cycle rise and fall pulses, a single-cycle long-press pulse, and a wrapping press counter for the design logic.

## Interface

- DEBOUNCE_CYCLES, 16, consecutive identical samples of sync_in required to accept a level change; legal range ≥1.
- LONG_CYCLES, 1024, clocks that level must stay high after an accepted rise before long_press fires; legal range ≥1.
- EVT_WIDTH, 8, width of press_count.
- Internal counter widths are derived with $clog2 from DEBOUNCE_CYCLES and LONG_CYCLES. They are not user parameters.

Ports:
- clk  in  1  single clock for everything; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- sync_in  in  1  synchronized input level from the upstream synchronizer. It is treated as glitch-prone but metastability-free.
- level  out  1  debounced level, registered.
- rise  out  1  one-cycle pulse on an accepted 0→1 change.
- fall  out  1  one-cycle pulse on an accepted 1→0 change.
- long_press  out  1  one-cycle pulse, at most once per accepted high period.
- press_count  out  EVT_WIDTH  count of accepted rises, modulo 2^EVT_WIDTH.

## Operation

- Reset is checked first and overrides all other logic. It drives state to S_LOW, level=0, rise=fall=long_press=0, press_count=0, and clears the debounce and hold counters.
- rst must be held ≥2 cycles so the upstream synchronizer is flushed before sync_in is trusted.
- FSM states: S_LOW, S_RISE_CHK, S_HIGH, S_FALL_CHK. level=1 only in S_HIGH and S_FALL_CHK.
- S_LOW:
  - sync_in=1 → S_RISE_CHK with dcnt=1.
  - If DEBOUNCE_CYCLES==1, sync_in=1 → S_HIGH directly (accepted rise).
- S_RISE_CHK:
  - sync_in=0 → S_LOW with dcnt=0 (glitch rejected, no pulse, no count).
  - sync_in=1 and dcnt==DEBOUNCE_CYCLES-1 → accepted rise, go to S_HIGH.
  - Otherwise dcnt++.
- S_HIGH:
  - sync_in=0 → S_FALL_CHK with dcnt=1.
  - If DEBOUNCE_CYCLES==1, sync_in=0 → S_LOW directly (accepted fall).
- S_FALL_CHK:
  - sync_in=1 → S_HIGH (glitch rejected; hold counter is NOT cleared).
  - sync_in=0 and dcnt==DEBOUNCE_CYCLES-1 → accepted fall, go to S_LOW.
  - Otherwise dcnt++.
- Accepted rise: level←1, rise←1 for one cycle, press_count←press_count+1 (wraps from all-ones to 0), hold←0, long_done←0.
- Accepted fall: level←0, fall←1 for one cycle.
- Hold counter: increments every cycle while level=1 and it is below LONG_CYCLES, then saturates.
- long_press fires for one cycle, and sets long_done, on the edge where hold reaches LONG_CYCLES.
- long_press is suppressed if an accepted fall occurs on the same edge.
- rise and fall can never be high in the same cycle.
- rise/fall pulses deassert on the next edge unconditionally.

## Timing

- All outputs are registered; there is no combinational path from sync_in to any output.
- Rise latency: if sync_in is sampled 1 on edges E0…E(D-1) (D=DEBOUNCE_CYCLES), then level, rise and the incremented press_count are visible after edge E(D-1). rise is high for exactly that one cycle.
- Fall latency is symmetric: D consecutive 0-samples, fall visible after the D-th edge.
- A single opposite sample at any point during a CHK state restarts the qualification.
- long_press becomes visible LONG_CYCLES clocks after the cycle in which rise was high, provided level stays 1. Glitch periods spent in S_FALL_CHK count toward hold.
- Reset mid-operation (any state, any counter value) returns all outputs to reset values on the next edge. No pulse is generated by reset itself.
- sync_in held high through reset: after reset release, the first accepted rise follows D samples later and increments press_count to 1.

## Test plan

- D=4, L=20. Reset 2 cycles, sync_in=0 → level=0, rise/fall/long_press=0, press_count=0 for 10 cycles.
- D=4. sync_in high for 4 edges → rise pulse exactly 1 cycle after the 4th edge, level=1, press_count=1. Then sync_in low 4 edges → single fall pulse, level=0.
- D=4. Bounce pattern 1,1,1,0,1,1,1,0 repeated → no rise, level stays 0, press_count unchanged. Repeat with 0-glitches during high → no fall, level stays 1.
- D=4, L=20. Hold high 40 cycles → long_press exactly once, 20 cycles after rise. A 1-cycle low glitch at hold=10 does not delay it. Release at hold=15 → no long_press.
- D=1, EVT_WIDTH=2. 5 clean presses → press_count 1,2,3,0,1. rise/fall appear 1 cycle after each sync_in change.
- Assert rst during S_RISE_CHK and during S_HIGH with hold=L-1 → all outputs 0 next cycle, no long_press or fall pulse emitted.

Source files
------------

// File: rtl/debounce_edge.sv
// debounce_edge: qualifies a synchronized, glitch-prone level and turns it into
// a clean debounced level plus rise/fall/long-press pulses and a press counter.
// All outputs come straight from flops; sync_in only feeds next-state logic.
module debounce_edge #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1024,
  parameter int EVT_WIDTH       = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sync_in,
  output logic                 level,
  output logic                 rise,
  output logic                 fall,
  output logic                 long_press,
  output logic [EVT_WIDTH-1:0] press_count
);

  // dcnt never needs to hold more than DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  // hold saturates at LONG_CYCLES, so it must be able to represent that value.
  localparam int HW = $clog2(LONG_CYCLES + 1);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] L_MAX  = HW'(LONG_CYCLES);
  localparam logic [HW-1:0] L_PRE  = HW'(LONG_CYCLES - 1);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_RISE_CHK = 2'd1,
    S_HIGH     = 2'd2,
    S_FALL_CHK = 2'd3
  } state_t;

  state_t                 state_q, state_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic                   long_done_q, long_done_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   long_press_q, long_press_d;
  logic [EVT_WIDTH-1:0]   press_count_q, press_count_d;
  logic                   acc_rise, acc_fall;

  // Next-state: debounce FSM, hold timer, long-press detection and press counter.
  always_comb begin
    state_d       = state_q;
    dcnt_d        = dcnt_q;
    hold_d        = hold_q;
    long_done_d   = long_done_q;
    press_count_d = press_count_q;
    acc_rise      = 1'b0;
    acc_fall      = 1'b0;

    case (state_q)
      S_LOW: begin
        if (sync_in) begin
          if (DEBOUNCE_CYCLES == 1) begin
            acc_rise = 1'b1;
          end else begin
            state_d = S_RISE_CHK;
            dcnt_d  = DW'(1);
          end
        end
      end
      S_RISE_CHK: begin
        if (!sync_in) begin
          state_d = S_LOW;
          dcnt_d  = '0;
        end else if (dcnt_q == D_LAST) begin
          acc_rise = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      S_HIGH: begin
        if (!sync_in) begin
          if (DEBOUNCE_CYCLES == 1) begin
            acc_fall = 1'b1;
          end else begin
            state_d = S_FALL_CHK;
            dcnt_d  = DW'(1);
          end
        end
      end
      S_FALL_CHK: begin
        // A rejected fall glitch returns to S_HIGH but keeps the hold timer running.
        if (sync_in) begin
          state_d = S_HIGH;
          dcnt_d  = '0;
        end else if (dcnt_q == D_LAST) begin
          acc_fall = 1'b1;
        end else begin
          dcnt_d = dcnt_q + DW'(1);
        end
      end
      default: begin
        state_d = S_LOW;
        dcnt_d  = '0;
      end
    endcase

    // Hold timer runs while the debounced level is high, saturating at LONG_CYCLES.
    if (level_q && (hold_q < L_MAX)) begin
      hold_d = hold_q + HW'(1);
    end

    // Long press fires on the edge where hold reaches LONG_CYCLES, unless the
    // level is being dropped on that same edge.
    long_press_d = level_q && !long_done_q && (hold_q == L_PRE) && !acc_fall;
    if (long_press_d) begin
      long_done_d = 1'b1;
    end

    if (acc_rise) begin
      state_d       = S_HIGH;
      dcnt_d        = '0;
      press_count_d = press_count_q + EVT_WIDTH'(1);
      hold_d        = '0;
      long_done_d   = 1'b0;
    end

    if (acc_fall) begin
      state_d = S_LOW;
      dcnt_d  = '0;
    end

    level_d = (state_d == S_HIGH) || (state_d == S_FALL_CHK);
    rise_d  = acc_rise;
    fall_d  = acc_fall;
  end

  // State and output registers; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_LOW;
      dcnt_q        <= '0;
      hold_q        <= '0;
      long_done_q   <= 1'b0;
      level_q       <= 1'b0;
      rise_q        <= 1'b0;
      fall_q        <= 1'b0;
      long_press_q  <= 1'b0;
      press_count_q <= '0;
    end else begin
      state_q       <= state_d;
      dcnt_q        <= dcnt_d;
      hold_q        <= hold_d;
      long_done_q   <= long_done_d;
      level_q       <= level_d;
      rise_q        <= rise_d;
      fall_q        <= fall_d;
      long_press_q  <= long_press_d;
      press_count_q <= press_count_d;
    end
  end

  assign level       = level_q;
  assign rise        = rise_q;
  assign fall        = fall_q;
  assign long_press  = long_press_q;
  assign press_count = press_count_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Scoreboard bench for debounce_edge: two instances (D=4/L=20/W=8 and
// D=1/W=2). Stimulus pushes expected pulse events with their edge index;
// a negedge monitor pops and compares whenever a pulse appears.
module tb_debounce_edge;

  logic       clk = 1'b0;
  logic       rst;
  logic       sin_a, sin_b;
  logic       level_a, rise_a, fall_a, long_a;
  logic [7:0] pc_a;
  logic       level_b, rise_b, fall_b, long_b;
  logic [1:0] pc_b;

  always #5 clk = ~clk;

  debounce_edge #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(20), .EVT_WIDTH(8)) dut_a (
    .clk(clk), .rst(rst), .sync_in(sin_a), .level(level_a), .rise(rise_a),
    .fall(fall_a), .long_press(long_a), .press_count(pc_a)
  );

  debounce_edge #(.DEBOUNCE_CYCLES(1), .LONG_CYCLES(1024), .EVT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .sync_in(sin_b), .level(level_b), .rise(rise_b),
    .fall(fall_b), .long_press(long_b), .press_count(pc_b)
  );

  // kind: 0 = rise, 1 = fall, 2 = long_press
  typedef struct {
    int kind;
    int cyc;
    int lvl;
    int pc;
  } evt_t;

  evt_t q_a[$];
  evt_t q_b[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  bit pat_lo [8] = '{1, 1, 1, 0, 1, 1, 1, 0};
  bit pat_hi [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
  int pcs_b  [5] = '{1, 2, 3, 0, 1};

  always @(posedge clk) cyc <= cyc + 1;

  // Drive one sample per edge; returns just after the edge that sampled it.
  task automatic step(input logic a, input logic b);
    sin_a = a;
    sin_b = b;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input int dut, input int kind, input int dcyc,
                            input int lvl, input int pc);
    evt_t e;
    e.kind = kind;
    e.cyc  = cyc + dcyc;
    e.lvl  = lvl;
    e.pc   = pc;
    if (dut == 0) q_a.push_back(e);
    else          q_b.push_back(e);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d (cyc=%0d)", name, act, exp, cyc);
    end
  endtask

  task automatic pop_cmp(input int dut, input int kind, input int lvl, input int pc);
    evt_t e;
    bit   empty;
    empty = (dut == 0) ? (q_a.size() == 0) : (q_b.size() == 0);
    checks++;
    if (empty) begin
      failures++;
      $display("FAIL dut%0d_unexpected_event kind=%0d cyc=%0d expected=none", dut, kind, cyc);
    end else begin
      if (dut == 0) e = q_a.pop_front();
      else          e = q_b.pop_front();
      if (e.kind != kind || e.cyc != cyc || e.lvl != lvl || e.pc != pc) begin
        failures++;
        $display("FAIL dut%0d_event actual kind=%0d cyc=%0d level=%0d pc=%0d expected kind=%0d cyc=%0d level=%0d pc=%0d",
                 dut, kind, cyc, lvl, pc, e.kind, e.cyc, e.lvl, e.pc);
      end else begin
        $display("dut%0d event kind=%0d cyc=%0d level=%0d pc=%0d ok", dut, kind, cyc, lvl, pc);
      end
    end
  endtask

  // Monitor: every pulse must match the next expected event.
  always @(negedge clk) begin
    if (rise_a) pop_cmp(0, 0, int'(level_a), int'(pc_a));
    if (fall_a) pop_cmp(0, 1, int'(level_a), int'(pc_a));
    if (long_a) pop_cmp(0, 2, int'(level_a), int'(pc_a));
    if (rise_b) pop_cmp(1, 0, int'(level_b), int'(pc_b));
    if (fall_b) pop_cmp(1, 1, int'(level_b), int'(pc_b));
    if (long_b) pop_cmp(1, 2, int'(level_b), int'(pc_b));
    if (rise_a && fall_a) chk("rise_fall_overlap_a", 1, 0);
    if (rise_b && fall_b) chk("rise_fall_overlap_b", 1, 0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    sin_a = 1'b0;
    sin_b = 1'b0;
    step(0, 0);
    step(0, 0);
    chk("reset_level_a", int'(level_a), 0);
    chk("reset_pc_a", int'(pc_a), 0);
    chk("reset_pulses_a", int'({rise_a, fall_a, long_a}), 0);
    chk("reset_level_b", int'(level_b), 0);
    chk("reset_pc_b", int'(pc_b), 0);
    rst = 1'b0;

    // Idle low
    for (int i = 0; i < 10; i++) begin
      step(0, 0);
      chk("idle_level_a", int'(level_a), 0);
      chk("idle_pc_a", int'(pc_a), 0);
    end

    // Clean press and release
    repeat (4) step(1, 0);
    expect_evt(0, 0, 0, 1, 1);
    step(1, 0);
    chk("rise_width_a", int'(rise_a), 0);
    repeat (4) step(0, 0);
    expect_evt(0, 1, 0, 0, 1);
    step(0, 0);
    chk("fall_width_a", int'(fall_a), 0);

    // Bounce while low: never 4 ones in a row
    for (int i = 0; i < 8; i++) step(pat_lo[i], 0);
    chk("bounce_lo_level_a", int'(level_a), 0);
    chk("bounce_lo_pc_a", int'(pc_a), 1);
    step(0, 0);

    // Press, then bounce while high: never 4 zeros in a row
    repeat (4) step(1, 0);
    expect_evt(0, 0, 0, 1, 2);
    for (int i = 0; i < 8; i++) step(pat_hi[i], 0);
    chk("bounce_hi_level_a", int'(level_a), 1);
    chk("bounce_hi_pc_a", int'(pc_a), 2);
    repeat (4) step(0, 0);
    expect_evt(0, 1, 0, 0, 2);
    repeat (2) step(0, 0);

    // Long hold with a 1-cycle low glitch at hold=10
    repeat (4) step(1, 0);
    expect_evt(0, 0, 0, 1, 3);
    expect_evt(0, 2, 20, 1, 3);
    for (int k = 1; k <= 40; k++) step((k == 11) ? 1'b0 : 1'b1, 1'b0);
    chk("long_hold_level_a", int'(level_a), 1);
    repeat (4) step(0, 0);
    expect_evt(0, 1, 0, 0, 3);
    repeat (2) step(0, 0);

    // Release at hold=15: no long press
    repeat (4) step(1, 0);
    expect_evt(0, 0, 0, 1, 4);
    repeat (15) step(1, 0);
    repeat (4) step(0, 0);
    expect_evt(0, 1, 0, 0, 4);
    repeat (25) step(0, 0);
    chk("short_hold_level_a", int'(level_a), 0);

    // D=1 instance: five presses with 2-bit wrapping count
    for (int i = 0; i < 5; i++) begin
      step(0, 1);
      expect_evt(1, 0, 0, 1, pcs_b[i]);
      step(0, 0);
      expect_evt(1, 1, 0, 0, pcs_b[i]);
    end
    step(0, 0);

    // Reset during S_RISE_CHK
    step(1, 0);
    step(1, 0);
    rst = 1'b1;
    step(1, 0);
    chk("rst_chk_level_a", int'(level_a), 0);
    chk("rst_chk_pc_a", int'(pc_a), 0);
    chk("rst_chk_pulses_a", int'({rise_a, fall_a, long_a}), 0);
    chk("rst_chk_pc_b", int'(pc_b), 0);
    step(1, 0);
    rst = 1'b0;

    // sync_in held high through reset: first rise after 4 samples, count 1
    repeat (4) step(1, 0);
    expect_evt(0, 0, 0, 1, 1);
    repeat (19) step(1, 0);
    chk("pre_rst_level_a", int'(level_a), 1);
    // Reset lands on the edge where hold would reach LONG_CYCLES
    rst = 1'b1;
    step(1, 0);
    chk("rst_high_level_a", int'(level_a), 0);
    chk("rst_high_pc_a", int'(pc_a), 0);
    chk("rst_high_pulses_a", int'({rise_a, fall_a, long_a}), 0);
    step(1, 0);
    rst = 1'b0;
    repeat (5) step(0, 0);

    @(negedge clk);
    #1;
    chk("queue_a_drained", q_a.size(), 0);
    chk("queue_b_drained", q_b.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
